// File: rtl/pd_4b5b_rx_deframer_if.sv
// Symbol-in / frame-out bundle for the USB-PD 4b5b receive deframer.
// slave is the deframer side, master is the symbol source / frame consumer.
interface pd_4b5b_rx_deframer_if;
    logic [4:0] sym_in;
    logic       sym_vld;
    logic       frame_start;
    logic [1:0] sop_type;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic       frame_end;
    logic       frame_ok;
    logic [2:0] err_code;
    logic       hard_rst;

    modport master (
        output sym_in, sym_vld,
        input  frame_start, sop_type, byte_out, byte_vld,
        input  frame_end, frame_ok, err_code, hard_rst
    );

    modport slave (
        input  sym_in, sym_vld,
        output frame_start, sop_type, byte_out, byte_vld,
        output frame_end, frame_ok, err_code, hard_rst
    );
endinterface

// File: rtl/pd_4b5b_rx_deframer.sv
// USB-PD receive deframer: ordered-set hunt, 4b5b decode, byte assembly, frame status.
// Define PD_RX_CRC_CHK_EN to build the CRC-32 residue check at EOP.
module pd_4b5b_rx_deframer #(
    parameter int MAX_BYTES = 34
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    pd_4b5b_rx_deframer_if.slave bus
);

    localparam logic [4:0] K_S1  = 5'b11000;
    localparam logic [4:0] K_S2  = 5'b10001;
    localparam logic [4:0] K_S3  = 5'b00110;
    localparam logic [4:0] K_R1  = 5'b00111;
    localparam logic [4:0] K_R2  = 5'b11001;
    localparam logic [4:0] K_EOP = 5'b01101;

    // Ordered sets, oldest symbol in the top slot.
    localparam logic [3:0][4:0] OS_SOP   = {K_S1, K_S1, K_S1, K_S2};
    localparam logic [3:0][4:0] OS_SOPP  = {K_S1, K_S1, K_S3, K_S3};
    localparam logic [3:0][4:0] OS_SOPPP = {K_S1, K_S3, K_S1, K_S3};
    localparam logic [3:0][4:0] OS_HRST  = {K_R1, K_R1, K_R1, K_R2};

    localparam logic [2:0] E_OK    = 3'd0;
    localparam logic [2:0] E_INVAL = 3'd1;
    localparam logic [2:0] E_KCODE = 3'd2;
    localparam logic [2:0] E_ODD   = 3'd3;
    localparam logic [2:0] E_OVFL  = 3'd4;
    localparam logic [2:0] E_SHORT = 3'd6;

    localparam logic [5:0] CNT_MAX  = 6'(MAX_BYTES);
    localparam logic [5:0] CNT_SAT  = 6'h3F;
    localparam logic [5:0] MIN_BYTES = 6'd6;

    typedef enum logic {HUNT, PAYLOAD} state_e;

    typedef struct packed {
        logic       data;
        logic       eop;
        logic       kcode;
        logic [3:0] nib;
    } sym_dec_t;

    function automatic sym_dec_t decode(input logic [4:0] s);
        sym_dec_t d;
        d      = '0;
        d.data = 1'b1;
        case (s)
            5'b11110: d.nib = 4'h0;
            5'b01001: d.nib = 4'h1;
            5'b10100: d.nib = 4'h2;
            5'b10101: d.nib = 4'h3;
            5'b01010: d.nib = 4'h4;
            5'b01011: d.nib = 4'h5;
            5'b01110: d.nib = 4'h6;
            5'b01111: d.nib = 4'h7;
            5'b10010: d.nib = 4'h8;
            5'b10011: d.nib = 4'h9;
            5'b10110: d.nib = 4'hA;
            5'b10111: d.nib = 4'hB;
            5'b11010: d.nib = 4'hC;
            5'b11011: d.nib = 4'hD;
            5'b11100: d.nib = 4'hE;
            5'b11101: d.nib = 4'hF;
            K_EOP: begin
                d.data = 1'b0;
                d.eop  = 1'b1;
            end
            K_S1, K_S2, K_S3, K_R1, K_R2: begin
                d.data  = 1'b0;
                d.kcode = 1'b1;
            end
            default: d.data = 1'b0;
        endcase
        return d;
    endfunction

`ifdef PD_RX_CRC_CHK_EN
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    logic [31:0] crc_q, crc_d;
`endif

    state_e          state_q, state_d;
    logic [3:0][4:0] win_q, win_d;
    logic            phase_q, phase_d;
    logic [3:0]      lo_q, lo_d;
    logic [5:0]      cnt_q, cnt_d;

    logic            frame_start_q, frame_start_d;
    logic [1:0]      sop_type_q, sop_type_d;
    logic [7:0]      byte_out_q, byte_out_d;
    logic            byte_vld_q, byte_vld_d;
    logic            frame_end_q, frame_end_d;
    logic            frame_ok_q, frame_ok_d;
    logic [2:0]      err_code_q, err_code_d;
    logic            hard_rst_q, hard_rst_d;

    sym_dec_t        dec;
    logic [3:0][4:0] win_nxt;
    logic            sop_hit;
    logic [1:0]      sop_kind;
    logic            close;
    logic [2:0]      err;

    assign dec     = decode(bus.sym_in);
    assign win_nxt = {win_q[2:0], bus.sym_in};

    always_comb begin
        sop_hit  = 1'b1;
        sop_kind = 2'd0;
        if (win_nxt == OS_SOP) begin
            sop_kind = 2'd0;
        end else if (win_nxt == OS_SOPP) begin
            sop_kind = 2'd1;
        end else if (win_nxt == OS_SOPPP) begin
            sop_kind = 2'd2;
        end else begin
            sop_hit = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        phase_d       = phase_q;
        lo_d          = lo_q;
        cnt_d         = cnt_q;
        sop_type_d    = sop_type_q;
        byte_out_d    = byte_out_q;
        frame_ok_d    = frame_ok_q;
        err_code_d    = err_code_q;
        frame_start_d = 1'b0;
        byte_vld_d    = 1'b0;
        frame_end_d   = 1'b0;
        hard_rst_d    = 1'b0;
        close         = 1'b0;
        err           = E_OK;
`ifdef PD_RX_CRC_CHK_EN
        crc_d         = crc_q;
`endif

        if (bus.sym_vld) begin
            case (state_q)
                HUNT: begin
                    win_d = win_nxt;
                    if (sop_hit) begin
                        frame_start_d = 1'b1;
                        sop_type_d    = sop_kind;
                        win_d         = '0;
                        phase_d       = 1'b0;
                        cnt_d         = '0;
                        state_d       = PAYLOAD;
`ifdef PD_RX_CRC_CHK_EN
                        crc_d         = CRC_INIT;
`endif
                    end else if (win_nxt == OS_HRST) begin
                        hard_rst_d = 1'b1;
                        win_d      = '0;
                    end
                end
                PAYLOAD: begin
                    if (dec.data) begin
                        if (!phase_q) begin
                            lo_d    = dec.nib;
                            phase_d = 1'b1;
                        end else if (cnt_q == CNT_MAX) begin
                            // The overflowing byte is dropped, not emitted.
                            close = 1'b1;
                            err   = E_OVFL;
                        end else begin
                            byte_out_d = {dec.nib, lo_q};
                            byte_vld_d = 1'b1;
                            phase_d    = 1'b0;
                            cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 6'd1;
`ifdef PD_RX_CRC_CHK_EN
                            crc_d      = crc_byte(crc_q, {dec.nib, lo_q});
`endif
                        end
                    end else if (dec.eop) begin
                        close = 1'b1;
                        if (phase_q) begin
                            err = E_ODD;
                        end else if (cnt_q < MIN_BYTES) begin
                            err = E_SHORT;
                        end else begin
`ifdef PD_RX_CRC_CHK_EN
                            err = (crc_q == CRC_RESIDUE) ? E_OK : 3'd5;
`else
                            err = E_OK;
`endif
                        end
                    end else begin
                        close = 1'b1;
                        err   = dec.kcode ? E_KCODE : E_INVAL;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (close) begin
            frame_end_d = 1'b1;
            err_code_d  = err;
            frame_ok_d  = (err == E_OK);
            phase_d     = 1'b0;
            win_d       = '0;
            state_d     = HUNT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= HUNT;
            win_q         <= '0;
            phase_q       <= 1'b0;
            lo_q          <= '0;
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            sop_type_q    <= '0;
            byte_out_q    <= '0;
            byte_vld_q    <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_ok_q    <= 1'b0;
            err_code_q    <= '0;
            hard_rst_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            phase_q       <= phase_d;
            lo_q          <= lo_d;
            cnt_q         <= cnt_d;
            frame_start_q <= frame_start_d;
            sop_type_q    <= sop_type_d;
            byte_out_q    <= byte_out_d;
            byte_vld_q    <= byte_vld_d;
            frame_end_q   <= frame_end_d;
            frame_ok_q    <= frame_ok_d;
            err_code_q    <= err_code_d;
            hard_rst_q    <= hard_rst_d;
        end
    end

`ifdef PD_RX_CRC_CHK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end
`endif

    assign bus.frame_start = frame_start_q;
    assign bus.sop_type    = sop_type_q;
    assign bus.byte_out    = byte_out_q;
    assign bus.byte_vld    = byte_vld_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.frame_ok    = frame_ok_q;
    assign bus.err_code    = err_code_q;
    assign bus.hard_rst    = hard_rst_q;

endmodule

// File: tb/tb_pd_4b5b_rx_deframer.sv
// Directed bench for pd_4b5b_rx_deframer: ordered sets, byte assembly, every frame status.
module tb_pd_4b5b_rx_deframer;

    localparam logic [4:0] K_S1  = 5'b11000;
    localparam logic [4:0] K_S2  = 5'b10001;
    localparam logic [4:0] K_S3  = 5'b00110;
    localparam logic [4:0] K_R1  = 5'b00111;
    localparam logic [4:0] K_R2  = 5'b11001;
    localparam logic [4:0] K_EOP = 5'b01101;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n_start, n_end, n_hrst, n_byte, n_both;

    pd_4b5b_rx_deframer_if bus ();

    pd_4b5b_rx_deframer #(.MAX_BYTES(34)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_start) n_start <= n_start + 1;
        if (bus.frame_end)   n_end   <= n_end + 1;
        if (bus.hard_rst)    n_hrst  <= n_hrst + 1;
        if (bus.byte_vld)    n_byte  <= n_byte + 1;
        if (bus.byte_vld && bus.frame_end) n_both <= n_both + 1;
    end

    function automatic logic [4:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 5'b11110;  4'h1: enc = 5'b01001;
            4'h2: enc = 5'b10100;  4'h3: enc = 5'b10101;
            4'h4: enc = 5'b01010;  4'h5: enc = 5'b01011;
            4'h6: enc = 5'b01110;  4'h7: enc = 5'b01111;
            4'h8: enc = 5'b10010;  4'h9: enc = 5'b10011;
            4'hA: enc = 5'b10110;  4'hB: enc = 5'b10111;
            4'hC: enc = 5'b11010;  4'hD: enc = 5'b11011;
            4'hE: enc = 5'b11100;  default: enc = 5'b11101;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns one falling edge later, after the DUT sampled s.
    task automatic send(input logic [4:0] s);
        bus.sym_in  = s;
        bus.sym_vld = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.sym_vld = 1'b0;
        bus.sym_in  = 5'b00000;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic emit);
        send(enc(b[3:0]));
        chk("lo_nibble_no_byte", 32'(bus.byte_vld), 32'd0);
        send(enc(b[7:4]));
        if (emit) begin
            chk("byte_vld", 32'(bus.byte_vld), 32'd1);
            chk("byte_out", 32'(bus.byte_out), 32'(b));
        end else begin
            chk("dropped_byte", 32'(bus.byte_vld), 32'd0);
        end
    endtask

    task automatic sop(input logic [1:0] t);
        logic [3:0][4:0] os;
        case (t)
            2'd0:    os = {K_S1, K_S1, K_S1, K_S2};
            2'd1:    os = {K_S1, K_S1, K_S3, K_S3};
            default: os = {K_S1, K_S3, K_S1, K_S3};
        endcase
        send(os[3]);
        send(os[2]);
        send(os[1]);
        chk("no_early_start", 32'(bus.frame_start), 32'd0);
        send(os[0]);
        chk("frame_start", 32'(bus.frame_start), 32'd1);
        chk("sop_type", 32'(bus.sop_type), 32'(t));
    endtask

    task automatic end_chk(input string tag, input logic [2:0] e);
        chk({tag, "_frame_end"}, 32'(bus.frame_end), 32'd1);
        chk({tag, "_err_code"}, 32'(bus.err_code), 32'(e));
        chk({tag, "_frame_ok"}, 32'(bus.frame_ok), 32'(e == 3'd0));
        chk({tag, "_no_byte"}, 32'(bus.byte_vld), 32'd0);
    endtask

    task automatic frame_a(input logic [7:0] last, input logic [2:0] e, input string tag);
        logic [7:0] fa [13];
        int b0, e0;
        fa = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
        fa[12] = last;
        b0 = n_byte;
        e0 = n_end;
        sop(2'd0);
        for (int i = 0; i < 13; i++) send_byte(fa[i], 1'b1);
        send(K_EOP);
        end_chk(tag, e);
        idle(2);
        chk({tag, "_byte_count"}, 32'(n_byte - b0), 32'd13);
        chk({tag, "_end_count"}, 32'(n_end - e0), 32'd1);
    endtask

    initial begin
        int s0, b0, e0, h0;
        logic [2:0] e_crc;
        checks = 0;
        errors = 0;
        n_start = 0; n_end = 0; n_hrst = 0; n_byte = 0; n_both = 0;
        rst_n = 1'b0;
        bus.sym_in  = 5'b00000;
        bus.sym_vld = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_pulses", 32'({bus.frame_start, bus.byte_vld, bus.frame_end, bus.hard_rst}), 32'd0);
        chk("rst_byte_out", 32'(bus.byte_out), 32'd0);
        chk("rst_sop_type", 32'(bus.sop_type), 32'd0);
        chk("rst_status", 32'({bus.frame_ok, bus.err_code}), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Good frame: "123456789" plus its CRC-32 0xCBF43926, LSB first
        frame_a(8'hCB, 3'd0, "good");

        // Corrupted CRC byte
`ifdef PD_RX_CRC_CHK_EN
        e_crc = 3'd5;
`else
        e_crc = 3'd0;
`endif
        frame_a(8'hCA, e_crc, "badcrc");

        // Garbage then SOP'', two bytes and a stray nibble
        b0 = n_byte;
        send(5'b11000);
        send(5'b00111);
        sop(2'd2);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send(enc(4'h0));
        send(K_EOP);
        end_chk("odd", 3'd3);
        idle(2);
        chk("odd_byte_count", 32'(n_byte - b0), 32'd2);

        // Hard Reset in HUNT, then data symbols must not start a frame
        s0 = n_start; h0 = n_hrst; b0 = n_byte; e0 = n_end;
        send(K_R1);
        send(K_R1);
        send(K_R1);
        chk("hrst_not_early", 32'(bus.hard_rst), 32'd0);
        send(K_R2);
        chk("hrst_pulse", 32'(bus.hard_rst), 32'd1);
        chk("hrst_no_start", 32'(bus.frame_start), 32'd0);
        send(enc(4'h5));
        chk("hrst_one_cycle", 32'(bus.hard_rst), 32'd0);
        send(enc(4'hA));
        send(K_EOP);
        idle(2);
        chk("hrst_count", 32'(n_hrst - h0), 32'd1);
        chk("hunt_no_start", 32'(n_start - s0), 32'd0);
        chk("hunt_no_bytes", 32'(n_byte - b0), 32'd0);
        chk("hunt_no_end", 32'(n_end - e0), 32'd0);

        // Gaps inside the ordered set are transparent
        send(K_S1);
        send(K_S1);
        idle(3);
        send(K_S1);
        send(K_S2);
        chk("gap_start", 32'(bus.frame_start), 32'd1);
        // Invalid symbol after a lone data symbol
        b0 = n_byte;
        send(enc(4'h7));
        send(5'b00000);
        end_chk("invalid", 3'd1);
        idle(2);
        chk("invalid_no_byte", 32'(n_byte - b0), 32'd0);

        // Unexpected K-code mid-frame
        sop(2'd1);
        send_byte(8'h5A, 1'b1);
        send(K_S1);
        end_chk("kcode", 3'd2);
        idle(1);

        // Too short: two bytes then EOP
        sop(2'd0);
        send_byte(8'hA0, 1'b1);
        send_byte(8'h0B, 1'b1);
        send(K_EOP);
        end_chk("short", 3'd6);
        idle(1);

        // Overflow: 34 bytes accepted, byte 35 dropped with err 4
        b0 = n_byte;
        sop(2'd0);
        for (int i = 0; i < 34; i++) send_byte(8'(i * 7 + 3), 1'b1);
        send_byte(8'hEE, 1'b0);
        end_chk("ovfl", 3'd4);
        idle(2);
        chk("ovfl_byte_count", 32'(n_byte - b0), 32'd34);

        // Reset mid-payload with sym_vld held high
        e0 = n_end;
        sop(2'd1);
        send_byte(8'hA5, 1'b1);
        bus.sym_in  = enc(4'h3);
        bus.sym_vld = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_byte_out", 32'(bus.byte_out), 32'd0);
        chk("arst_sop_type", 32'(bus.sop_type), 32'd0);
        chk("arst_status", 32'({bus.frame_ok, bus.err_code}), 32'd0);
        chk("arst_pulses", 32'({bus.frame_start, bus.byte_vld, bus.frame_end, bus.hard_rst}), 32'd0);
        repeat (2) @(negedge clk);
        bus.sym_vld = 1'b0;
        rst_n = 1'b1;
        idle(2);
        chk("arst_no_end", 32'(n_end - e0), 32'd0);
        frame_a(8'hCB, 3'd0, "after_rst");

        chk("never_byte_and_end", 32'(n_both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
